seq_divider: RTL and testbench
==============================

// Module: seq_divider
// PURPOSE
//  Parametrised multi-cycle restoring divider. Successor to the 6/3-bit combinational array divider.
//  One quotient bit per clock; start/ready/done handshake; explicit divide-by-zero flag.
//  Sits beside the adder/ALU datapath as the DIV/MOD execution unit.
// PARAMETERS
//  WIDTH   8   dividend, divisor, quotient and remainder width in bits (>=2)
// PORTS
//  clk          in   1      single clock; all state changes on posedge clk
//  rst          in   1      synchronous, active-high reset
//  start        in   1      request; accepted only when ready=1
//  sign         in   1      1 = operands are two's complement (see CONFIGURATION)
//  dividend     in   WIDTH  numerator; sampled on the accept cycle only
//  divisor      in   WIDTH  denominator; sampled on the accept cycle only
//  ready        out  1      1 in IDLE and DONE; a new start is accepted
//  done         out  1      one-cycle pulse when quotient/remainder become valid
//  quotient     out  WIDTH  result; held from done until the next accept
//  remainder    out  WIDTH  result; held from done until the next accept
//  div_by_zero  out  1      set with done when divisor==0; held with the results
// BEHAVIOUR
//  Reset: state=IDLE, ready=1, done=0, quotient=0, remainder=0, div_by_zero=0, counter=0.
//  A reset in the middle of RUN aborts the operation; no done is produced.
//  FSM: IDLE -start-> RUN (divisor!=0) | DONE (divisor==0); RUN -count==0-> DONE; DONE -start-> as IDLE, else IDLE.
//  Accept cycle T: latch |dividend| and |divisor|, latch the result signs, counter=WIDTH.
//   ready=0 from T+1 onwards.
//  RUN, each cycle:
//   - shift the partial remainder (WIDTH+1 bits) left and bring in the next dividend MSB.
//   - subtract the divisor.
//   - if the difference is non-negative, keep it and set quotient bit=1; otherwise restore and set the bit to 0.
//   - decrement the counter.
//  Latency: done=1 in cycle T+WIDTH+1; results are valid in that same cycle. Next start may be accepted in that cycle.
//  start while ready=0: ignored, no queuing; operand changes during RUN: no effect.
//  Divide by zero: done at T+1; quotient = all ones; remainder = dividend (unmodified); div_by_zero=1.
//  div_by_zero clears on the next accept.
//  Unsigned: quotient = floor(dividend/divisor); remainder < divisor.
//  Signed (sign=1, macro defined):
//   - the quotient truncates toward zero; the remainder takes the sign of the dividend.
//   - negation uses ~x+1 at WIDTH+1 bits, so -2^(WIDTH-1) is handled.
//   - overflow -2^(WIDTH-1) / -1 gives quotient = -2^(WIDTH-1) (wraps), remainder = 0, div_by_zero = 0.
//  done is never asserted for two consecutive cycles unless a back-to-back divide-by-zero start occurs.
// CONFIGURATION
//  SEQ_DIV_SIGNED_EN defined: the sign input selects signed or unsigned operation, as above.
//  SEQ_DIV_SIGNED_EN undefined: the sign input is ignored and all operations are unsigned.
//   The operand abs/negate logic is not generated.
// TESTING (WIDTH=8 unless noted)
//  1. Unsigned 100/7, start at T: ready=0 at T+1..T+8; done at T+9; q=14, r=2, div_by_zero=0.
//  2. Divide by zero, 55/0: done at T+1; q=8'hFF, r=55, div_by_zero=1.
//     Next start with 9/3 gives q=3, r=0, div_by_zero=0.
//  3. Signed (macro on), -7/2: q=-3 (8'hFD), r=-1 (8'hFF).
//     7/-2: q=-3, r=1. -128/-1: q=8'h80, r=0.
//  4. Start pulsed at T+3 during RUN with different operands: ignored; the original result is unchanged.
//     Back-to-back start on the done cycle gives a second result at +9 cycles.
//  5. rst asserted at T+4 mid-RUN: next cycle ready=1, done=0, q=r=0; no done ever appears for the aborted op.
//  6. Exhaustive run at WIDTH=4, all dividend/divisor pairs, sign=0 and sign=1, against a reference model; macro off:
//     sign=1 still yields unsigned results.

Source files
------------

// File: rtl/seq_divider_if.sv
// Start/ready/done handshake and operand/result bundle for seq_divider.
interface seq_divider_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             sign;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             ready;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, sign, dividend, divisor,
    input  ready, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, sign, dividend, divisor,
    output ready, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider: one quotient bit per clock, divide-by-zero flag.
// Define SEQ_DIV_SIGNED_EN to honour the sign input (two's complement operands).
module seq_divider #(
  parameter int WIDTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  seq_divider_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic             ready, done, accept, dvs_zero;
  logic [WIDTH-1:0] quo_r, rem_r;
  logic             dbz_r;

  logic [WIDTH-1:0] part_rem, quo_w, dvs_w;
  logic [WIDTH-1:0] dvd_mag, dvs_mag;
  logic [WIDTH:0]   shifted, diff;
  logic             quo_bit;
  logic [WIDTH-1:0] rem_step, quo_step, quo_fin, rem_fin;

  assign dvs_zero = (bus.divisor == '0);
  assign accept   = bus.start && ready;

  // One restoring step: shift in the next dividend bit, trial-subtract, keep or restore
  assign shifted  = {part_rem, quo_w[WIDTH-1]};
  assign diff     = shifted - {1'b0, dvs_w};
  assign quo_bit  = ~diff[WIDTH];
  assign rem_step = quo_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  assign quo_step = {quo_w[WIDTH-2:0], quo_bit};

`ifdef SEQ_DIV_SIGNED_EN
  logic dvd_neg, dvs_neg, neg_q, neg_r;

  function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] x);
    logic [WIDTH:0] ext;
    ext = ~{x[WIDTH-1], x} + 1'b1;
    return ext[WIDTH-1:0];
  endfunction

  assign dvd_neg = bus.sign & bus.dividend[WIDTH-1];
  assign dvs_neg = bus.sign & bus.divisor[WIDTH-1];
  assign dvd_mag = dvd_neg ? negate(bus.dividend) : bus.dividend;
  assign dvs_mag = dvs_neg ? negate(bus.divisor) : bus.divisor;
  // Magnitude results get their signs back: quotient toward zero, remainder follows dividend
  assign quo_fin = neg_q ? negate(quo_step) : quo_step;
  assign rem_fin = neg_r ? negate(rem_step) : rem_step;

  always_ff @(posedge clk) begin
    if (accept) begin
      neg_q <= dvd_neg ^ dvs_neg;
      neg_r <= dvd_neg;
    end
  end
`else
  logic sign_unused;
  assign sign_unused = bus.sign;
  assign dvd_mag     = bus.dividend;
  assign dvs_mag     = bus.divisor;
  assign quo_fin     = quo_step;
  assign rem_fin     = rem_step;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE, DONE: begin
        ready     = 1'b1;
        done      = (state == DONE);
        state_nxt = IDLE;
        if (bus.start) state_nxt = dvs_zero ? DONE : RUN;
      end
      // Counter reaches zero on the edge that retires the last bit
      RUN:     if (cnt == CW'(1)) state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      quo_r <= '0;
      rem_r <= '0;
      dbz_r <= 1'b0;
    end else if (accept) begin
      cnt   <= CW'(WIDTH);
      dbz_r <= dvs_zero;
      if (dvs_zero) begin
        quo_r <= '1;
        rem_r <= bus.dividend;
      end
    end else if (state == RUN) begin
      cnt <= cnt - 1'b1;
      if (cnt == CW'(1)) begin
        quo_r <= quo_fin;
        rem_r <= rem_fin;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      part_rem <= '0;
      quo_w    <= dvd_mag;
      dvs_w    <= dvs_mag;
    end else if (state == RUN) begin
      part_rem <= rem_step;
      quo_w    <= quo_step;
    end
  end

  assign bus.ready       = ready;
  assign bus.done        = done;
  assign bus.quotient    = quo_r;
  assign bus.remainder   = rem_r;
  assign bus.div_by_zero = dbz_r;
endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: vector table, handshake corner cases, random and exhaustive
// comparisons against an integer-arithmetic reference.
module tb_seq_divider;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

`ifdef SEQ_DIV_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif

  seq_divider_if #(.WIDTH(8)) b8 ();
  seq_divider_if #(.WIDTH(4)) b4 ();

  seq_divider #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(b8));
  seq_divider #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .bus(b4));

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       s;
    logic [7:0] q;
    logic [7:0] r;
    logic       z;
    int         lat;
  } vec_t;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain integer division, with Verilog's truncating / and dividend-signed %
  function automatic void model(input int w, input logic [31:0] a, input logic [31:0] b,
                                input logic s, output logic [31:0] q, output logic [31:0] r,
                                output logic z);
    logic [31:0] mask;
    int sa, sb;
    mask = (32'd1 << w) - 32'd1;
    z = (b == 32'd0);
    if (z) begin
      q = mask;
      r = a;
    end else if (s & SIGNED_EN) begin
      sa = a[w-1] ? int'(a) - (1 << w) : int'(a);
      sb = b[w-1] ? int'(b) - (1 << w) : int'(b);
      q = 32'(sa / sb) & mask;
      r = 32'(sa % sb) & mask;
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic s,
                     output logic [7:0] q, output logic [7:0] r, output logic z,
                     output int lat, output bit rdy_ok);
    @(negedge clk);
    b8.start = 1'b1; b8.sign = s; b8.dividend = a; b8.divisor = b;
    @(posedge clk); #1;
    b8.start = 1'b0;
    lat = 0;
    rdy_ok = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      if (b8.done) begin
        lat = i;
        break;
      end
      if (b8.ready) rdy_ok = 1'b0;
      @(posedge clk); #1;
    end
    q = b8.quotient; r = b8.remainder; z = b8.div_by_zero;
  endtask

  task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic s,
                     output logic [3:0] q, output logic [3:0] r, output logic z,
                     output int lat);
    @(negedge clk);
    b4.start = 1'b1; b4.sign = s; b4.dividend = a; b4.divisor = b;
    @(posedge clk); #1;
    b4.start = 1'b0;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      if (b4.done) begin
        lat = i;
        break;
      end
      @(posedge clk); #1;
    end
    q = b4.quotient; r = b4.remainder; z = b4.div_by_zero;
  endtask

  vec_t        tbl[12];
  logic [7:0]  q8, r8;
  logic [3:0]  q4, r4;
  logic        z;
  logic [31:0] eq, er;
  logic        ez;
  logic [7:0]  ra, rb;
  logic        rs;
  int          lat, found, elat;
  bit          rdy_ok;

  initial begin
    tbl[0]  = '{8'd100, 8'd7,   1'b0, 8'd14,  8'd2,  1'b0, 9};
    tbl[1]  = '{8'd55,  8'd0,   1'b0, 8'hFF,  8'd55, 1'b1, 1};
    tbl[2]  = '{8'd9,   8'd3,   1'b0, 8'd3,   8'd0,  1'b0, 9};
    tbl[3]  = '{8'd200, 8'd0,   1'b0, 8'hFF,  8'd200,1'b1, 1};
    tbl[4]  = '{8'd0,   8'd0,   1'b0, 8'hFF,  8'd0,  1'b1, 1};
    tbl[5]  = '{8'd255, 8'd1,   1'b0, 8'd255, 8'd0,  1'b0, 9};
    tbl[6]  = '{8'd255, 8'd255, 1'b0, 8'd1,   8'd0,  1'b0, 9};
    tbl[7]  = '{8'd3,   8'd200, 1'b0, 8'd0,   8'd3,  1'b0, 9};
`ifdef SEQ_DIV_SIGNED_EN
    tbl[8]  = '{8'hF9,  8'h02,  1'b1, 8'hFD,  8'hFF, 1'b0, 9};
    tbl[9]  = '{8'h07,  8'hFE,  1'b1, 8'hFD,  8'h01, 1'b0, 9};
    tbl[10] = '{8'h80,  8'hFF,  1'b1, 8'h80,  8'h00, 1'b0, 9};
`else
    tbl[8]  = '{8'hF9,  8'h02,  1'b1, 8'h7C,  8'h01, 1'b0, 9};
    tbl[9]  = '{8'h07,  8'hFE,  1'b1, 8'h00,  8'h07, 1'b0, 9};
    tbl[10] = '{8'h80,  8'hFF,  1'b1, 8'h00,  8'h80, 1'b0, 9};
`endif
    tbl[11] = '{8'hFB,  8'h00,  1'b1, 8'hFF,  8'hFB, 1'b1, 1};

    rst = 1'b1;
    b8.start = 1'b0; b8.sign = 1'b0; b8.dividend = '0; b8.divisor = '0;
    b4.start = 1'b0; b4.sign = 1'b0; b4.dividend = '0; b4.divisor = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    chk("rst_ready", 32'(b8.ready), 32'd1);
    chk("rst_done",  32'(b8.done), 32'd0);
    chk("rst_q",     32'(b8.quotient), 32'd0);
    chk("rst_r",     32'(b8.remainder), 32'd0);
    chk("rst_dbz",   32'(b8.div_by_zero), 32'd0);

    // Table: each op starts on the previous done cycle, so back-to-back accepts are exercised
    for (int i = 0; i < 12; i++) begin
      op8(tbl[i].a, tbl[i].b, tbl[i].s, q8, r8, z, lat, rdy_ok);
      chk($sformatf("vec%0d_q", i),   32'(q8), 32'(tbl[i].q));
      chk($sformatf("vec%0d_r", i),   32'(r8), 32'(tbl[i].r));
      chk($sformatf("vec%0d_dbz", i), 32'(z),  32'(tbl[i].z));
      chk($sformatf("vec%0d_lat", i), 32'(lat), 32'(tbl[i].lat));
      if (tbl[i].lat > 1) chk($sformatf("vec%0d_ready_low", i), 32'(rdy_ok), 32'd1);
    end

    // Start pulsed mid-RUN with other operands must be ignored
    @(negedge clk);
    b8.start = 1'b1; b8.sign = 1'b0; b8.dividend = 8'd100; b8.divisor = 8'd7;
    @(posedge clk); #1 b8.start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    b8.start = 1'b1; b8.dividend = 8'd50; b8.divisor = 8'd5;
    @(posedge clk); #1 b8.start = 1'b0;
    found = 0;
    for (int i = 4; i <= 30; i++) begin
      if (b8.done) begin
        found = i;
        break;
      end
      @(posedge clk); #1;
    end
    chk("ign_lat", 32'(found), 32'd9);
    chk("ign_q",   32'(b8.quotient), 32'd14);
    chk("ign_r",   32'(b8.remainder), 32'd2);
    @(posedge clk); #1;
    chk("done_pulse", 32'(b8.done), 32'd0);
    chk("hold_q",     32'(b8.quotient), 32'd14);

    op8(8'd20, 8'd6, 1'b0, q8, r8, z, lat, rdy_ok);
    chk("b2b_a", {8'(lat), 7'd0, z, q8, r8}, {8'd9, 7'd0, 1'b0, 8'd3, 8'd2});
    op8(8'd9, 8'd3, 1'b0, q8, r8, z, lat, rdy_ok);
    chk("b2b_b", {8'(lat), 7'd0, z, q8, r8}, {8'd9, 7'd0, 1'b0, 8'd3, 8'd0});

    // Reset during RUN aborts: no done for that operation
    @(negedge clk);
    b8.start = 1'b1; b8.dividend = 8'd200; b8.divisor = 8'd3;
    @(posedge clk); #1 b8.start = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_ready", 32'(b8.ready), 32'd1);
    chk("abort_done",  32'(b8.done), 32'd0);
    chk("abort_q",     32'(b8.quotient), 32'd0);
    chk("abort_r",     32'(b8.remainder), 32'd0);
    rst = 1'b0;
    found = 0;
    for (int i = 0; i < 20; i++) begin
      if (b8.done) found++;
      @(posedge clk); #1;
    end
    chk("abort_no_done", 32'(found), 32'd0);

    for (int n = 0; n < 200; n++) begin
      ra = 8'($urandom);
      rb = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom);
      rs = 1'($urandom);
      model(8, 32'(ra), 32'(rb), rs, eq, er, ez);
      elat = (rb == 8'd0) ? 1 : 9;
      op8(ra, rb, rs, q8, r8, z, lat, rdy_ok);
      chk($sformatf("rnd %0h/%0h s%0d", ra, rb, rs), {8'(lat), 7'd0, z, q8, r8},
          {8'(elat), 7'd0, ez, eq[7:0], er[7:0]});
    end

    for (int s = 0; s < 2; s++) begin
      for (int a = 0; a < 16; a++) begin
        for (int b = 0; b < 16; b++) begin
          model(4, 32'(a), 32'(b), s[0], eq, er, ez);
          elat = (b == 0) ? 1 : 5;
          op4(4'(a), 4'(b), s[0], q4, r4, z, lat);
          chk($sformatf("exh4 %0d/%0d s%0d", a, b, s), {8'(lat), 15'd0, z, q4, r4},
              {8'(elat), 15'd0, ez, eq[3:0], er[3:0]});
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
